// File: rtl/song_sequencer.sv
// Note-stream playback controller: directory of 4 songs, tempo prescaler, and
// a fetch/wait/play FSM that turns host commands into a timed note/gate stream.
module song_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int TICK_DIV = 8
) (
  input  logic              oclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_song,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_end,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_song,
  output logic              cmd_ready,
  input  logic              loop,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [7:0]        note,
  output logic              gate,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pos
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] OP_PLAY  = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_PAUSE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_PAUSED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        song_q, song_d;
  logic [7:0]        note_q, note_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        tick_q, tick_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] start_q [4];
  logic [ADDR_W-1:0] end_q   [4];

  logic cmd_acc, tick_wrap, note_last, end_hit;

  assign cmd_ready = (state_q != S_FETCH) && (state_q != S_WAIT);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign tick_wrap = (pre_q == PMAX);
  assign note_last = tick_wrap && (tick_q == len_q);

  // Directory writes land immediately; playback only reads start/end on
  // PLAY, loop restart or note end, so in-flight songs see the new values
  // only at those points.
  always_ff @(posedge oclk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
      end
    end else if (cfg_we) begin
      start_q[cfg_song] <= cfg_start;
      end_q[cfg_song]   <= cfg_end;
    end
  end

  always_ff @(posedge oclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      song_q  <= '0;
      note_q  <= '0;
      len_q   <= '0;
      tick_q  <= '0;
      pre_q   <= '0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      song_q  <= song_d;
      note_q  <= note_d;
      len_q   <= len_d;
      tick_q  <= tick_d;
      pre_q   <= pre_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    song_d  = song_q;
    note_d  = note_q;
    len_d   = len_q;
    tick_d  = tick_q;
    pre_d   = pre_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    end_hit = 1'b0;

    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_data[15:8] == 8'd0) begin
          end_hit = 1'b1;
        end else begin
          note_d  = mem_data[7:0];
          len_d   = mem_data[15:8];
          tick_d  = 8'd1;
          pre_d   = '0;
          pos_d   = addr_q;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // The cycle a pause lands in still counts as played, except the
        // note's final cycle, which is replayed after resume.
        if (!note_last) begin
          if (tick_wrap) begin
            pre_d  = '0;
            tick_d = tick_q + 8'd1;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        if (cmd_acc && cmd_op == OP_PAUSE) begin
          state_d = S_PAUSED;
        end else if (note_last) begin
          pre_d = '0;
          if (addr_q == end_q[song_q]) begin
            end_hit = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_PAUSED: if (cmd_acc && cmd_op == OP_PAUSE) state_d = S_PLAY;
      default: ;
    endcase

    if (end_hit) begin
      if (loop) begin
        addr_d  = start_q[song_q];
        state_d = S_FETCH;
      end else begin
        note_d  = 8'd0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    // Commands take priority over any note-end handling in the same cycle.
    if (cmd_acc && cmd_op == OP_PLAY) begin
      addr_d  = start_q[cmd_song];
      song_d  = cmd_song;
      done_d  = 1'b0;
      state_d = S_FETCH;
    end else if (cmd_acc && cmd_op == OP_STOP) begin
      note_d  = 8'd0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  assign mem_re   = (state_q == S_FETCH);
  assign mem_addr = addr_q;
  assign note     = note_q;
  assign gate     = (state_q == S_PLAY) && !note_last;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign pos      = pos_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: behavioural note memory plus
// hand-computed note lengths, gate gaps, addresses and done pulses.
module tb_song_sequencer;
  localparam int AW = 10;

  logic          oclk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_song;
  logic [AW-1:0] cfg_start, cfg_end;
  logic          cmd_valid;
  logic [1:0]    cmd_op, cmd_song;
  logic          cmd_ready;
  logic          loop;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [7:0]    note;
  logic          gate, busy, done;
  logic [AW-1:0] pos;

  logic [15:0] mem [1024];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int rdy_lo   = 0;
  int reads    = 0;
  int rd10     = 0;

  song_sequencer #(.ADDR_W(AW), .TICK_DIV(8)) dut (
    .oclk(oclk), .rst(rst),
    .cfg_we(cfg_we), .cfg_song(cfg_song), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_song(cmd_song), .cmd_ready(cmd_ready),
    .loop(loop), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .note(note), .gate(gate), .busy(busy), .done(done), .pos(pos)
  );

  always #5 oclk = ~oclk;

  always @(posedge oclk) mem_data <= mem[mem_addr];

  always @(negedge oclk) begin
    if (done) done_cnt++;
    if (!cmd_ready) rdy_lo++;
    if (mem_re) reads++;
    if (mem_re && mem_addr == 10'd10) rd10++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge oclk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] s);
    cmd_valid = 1'b1; cmd_op = op; cmd_song = s;
    step();
    cmd_valid = 1'b0; cmd_op = 2'b00;
  endtask

  task automatic dir_wr(input logic [1:0] s, input logic [AW-1:0] a, input logic [AW-1:0] e);
    cfg_we = 1'b1; cfg_song = s; cfg_start = a; cfg_end = e;
    step();
    cfg_we = 1'b0;
  endtask

  // Sample is on a FETCH cycle: check it, walk through WAIT into first PLAY cycle.
  task automatic gap(input string tag, input logic [AW-1:0] ea);
    chk({tag, "_re"}, mem_re, 1);
    chk({tag, "_addr"}, mem_addr, ea);
    chk({tag, "_rdyF"}, cmd_ready, 0);
    chk({tag, "_gateF"}, gate, 0);
    step();
    chk({tag, "_rdyW"}, cmd_ready, 0);
    step();
  endtask

  // Sample is on a PLAY cycle: count PLAY cycles until the next fetch or done.
  task automatic note_run(input string tag, input logic [7:0] en, input int ec);
    int n = 0, g = 0, bn = 0;
    while (!mem_re && !done && n < 200) begin
      n++;
      if (gate) g++;
      if (note != en) bn++;
      step();
    end
    chk({tag, "_len"}, n, ec);
    chk({tag, "_gate"}, g, ec - 1);
    chk({tag, "_note"}, bn, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_note"}, note, 0);
    chk({tag, "_gate"}, gate, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, cmd_ready, 1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[4] = 16'h0211; mem[5] = 16'h0122; mem[6] = 16'h0333;
    mem[8] = 16'h0144; mem[9] = 16'h0000; mem[10] = 16'h0155;
    mem[10'h3FE] = 16'h0101; mem[10'h3FF] = 16'h0102;
    mem[0] = 16'h0103; mem[1] = 16'h0104;
    rst = 1'b1; cfg_we = 0; cfg_song = 0; cfg_start = 0; cfg_end = 0;
    cmd_valid = 0; cmd_op = 0; cmd_song = 0; loop = 0;
    step(); step();
    rst = 1'b0;
    chk_idle("rst");
    chk("rst_done", done, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pos", pos, 0);

    // Basic playback of song 0
    dir_wr(2'd0, 10'd4, 10'd6);
    dir_wr(2'd1, 10'd8, 10'd10);
    dir_wr(2'd2, 10'h3FE, 10'h001);
    cmd(2'b01, 2'd0);
    chk("p1_busy", busy, 1);
    gap("p1_f4", 10'd4);
    chk("p1_pos4", pos, 4);
    note_run("p1_n11", 8'h11, 16);
    chk("p1_hold", note, 8'h11);
    gap("p1_f5", 10'd5);
    chk("p1_pos5", pos, 5);
    note_run("p1_n22", 8'h22, 8);
    gap("p1_f6", 10'd6);
    note_run("p1_n33", 8'h33, 24);
    chk("p1_done", done, 1);
    chk_idle("p1_end");
    step();
    chk("p1_done_pulse", done, 0);

    // Looping, then STOP
    loop = 1'b1;
    d0 = done_cnt;
    cmd(2'b01, 2'd0);
    gap("lp_f4", 10'd4);
    note_run("lp_n11", 8'h11, 16);
    gap("lp_f5", 10'd5);
    note_run("lp_n22", 8'h22, 8);
    gap("lp_f6", 10'd6);
    note_run("lp_n33", 8'h33, 24);
    gap("lp_rewind", 10'd4);
    chk("lp_replay", note, 8'h11);
    step(); step();
    cmd(2'b10, 2'd0);
    chk_idle("lp_stop");
    chk("lp_nodone", done_cnt - d0, 0);
    loop = 1'b0;

    // Pause during the third cycle of 0x0211
    cmd(2'b01, 2'd0);
    gap("pz_f4", 10'd4);
    step(); step();
    cmd(2'b11, 2'd0);
    begin
      int g = 0, nb = 0;
      for (int i = 0; i < 20; i++) begin
        if (gate) g++;
        if (note != 8'h11) nb++;
        if (i < 19) step();
      end
      chk("pz_gate", g, 0);
      chk("pz_note", nb, 0);
      chk("pz_busy", busy, 1);
    end
    cmd(2'b11, 2'd0);
    note_run("pz_rem", 8'h11, 13);
    gap("pz_f5", 10'd5);
    cmd(2'b10, 2'd0);
    chk_idle("pz_stop");

    // End marker after first note of song 1
    d0 = done_cnt;
    cmd(2'b01, 2'd1);
    gap("em_f8", 10'd8);
    note_run("em_n44", 8'h44, 8);
    gap("em_f9", 10'd9);
    chk("em_done", done, 1);
    chk_idle("em_end");
    step(); step();
    chk("em_no10", rd10, 0);
    chk("em_dcnt", done_cnt - d0, 1);

    // Address wrap, cmd_ready low only during FETCH/WAIT
    rdy_lo = 0; reads = 0;
    cmd(2'b01, 2'd2);
    gap("wr_f3fe", 10'h3FE);
    note_run("wr_n1", 8'h01, 8);
    gap("wr_f3ff", 10'h3FF);
    note_run("wr_n2", 8'h02, 8);
    gap("wr_f000", 10'h000);
    note_run("wr_n3", 8'h03, 8);
    gap("wr_f001", 10'h001);
    note_run("wr_n4", 8'h04, 8);
    chk("wr_done", done, 1);
    step();
    chk("wr_reads", reads, 4);
    chk("wr_rdylo", rdy_lo, 8);

    // Reset mid-note with concurrent PLAY and cfg write
    cmd(2'b01, 2'd0);
    gap("rs_f4", 10'd4);
    step(); step();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_song = 2'd1;
    cfg_we = 1'b1; cfg_song = 2'd3; cfg_start = 10'd20; cfg_end = 10'd21;
    step();
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cfg_we = 1'b0;
    chk_idle("rs");
    chk("rs_done", done, 0);
    chk("rs_re", mem_re, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_pos", pos, 0);
    cmd(2'b01, 2'd0);
    chk("rs_dir0", mem_addr, 0);
    step(); step();
    cmd(2'b10, 2'd0);
    cmd(2'b01, 2'd3);
    chk("rs_dir3", mem_addr, 0);
    step(); step();
    cmd(2'b10, 2'd0);
    chk_idle("rs_fin");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
